// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU: operation codes, flag bit
// positions inside the 4-bit flag word, and the control FSM states.
package alu_pkg;

    // Operation codes issued by the control unit; every other code is illegal.
    typedef enum logic [3:0] {
        OP_ADD   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_AND   = 4'b0011,
        OP_OR    = 4'b0100,
        OP_NOTA  = 4'b0101,
        OP_XOR   = 4'b0110,
        OP_PASSA = 4'b0111,
        OP_ADC   = 4'b1000,
        OP_SHL   = 4'b1001,
        OP_SHR   = 4'b1010,
        OP_MUL   = 4'b1011
    } op_t;

    // Bit positions of the status flags in the {V, Z, N, C} word.
    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    // Control states: single-cycle work happens in IDLE, MUL runs the
    // shift-add multiplier, DONE writes the product back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Unsigned shift-add multiplier, one partial-product step per clock.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any multiply)
//   i_start    load operands and begin a multiply this edge
//   i_a, i_b   WIDTH-bit unsigned operands
//   o_done     high during the cycle whose closing edge performs the last step;
//              o_product is complete after that edge
//   o_product  2*WIDTH-bit running / final product
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    // Classic shift-add: the multiplicand moves left and the multiplier moves
    // right each step, so bit 0 of the multiplier always selects whether the
    // current shifted multiplicand is accumulated. The step counter runs
    // 0..WIDTH-1 and the engine goes idle after the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Flagging the final step combinationally lets the sequencer leave its
    // multiply state on the very edge that completes the product.
    assign o_done    = r_busy && (r_cnt == LAST_STEP);
    assign o_product = r_prod;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Parametrised sequential ALU with registered result and flags written in
// the same cycle, valid/ready issue handshake and a multi-cycle multiply.
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready issue handshake; in_ready is high only in IDLE
//   op, a, b          operation code and WIDTH-bit operands
//   result            registered WIDTH-bit result
//   flags             registered {V, Z, N, C}
//   out_valid         one-cycle pulse when result/flags were just written
//   illegal           pulses with out_valid for an unknown op
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_valid,
    output logic             illegal
);

    state_t             r_state;
    state_t             w_nextState;
    logic               w_accept;
    logic               w_mulStart;
    logic               w_mulDone;
    logic [2*WIDTH-1:0] w_prod;

    logic               r_pend;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_legal;
    logic [3:0]         w_flagsNext;
    logic [3:0]         w_mulFlags;

    assign w_accept   = in_valid && in_ready;
    assign w_mulStart = w_accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mulStart),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mulDone),
        .o_product (w_prod)
    );

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a multiply parks the ALU until the multiplier signals
    // its last step, then spends one DONE cycle writing the product back.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (w_mulStart) begin
                    w_nextState = ST_MUL;
                end
            end
            ST_MUL: begin
                if (w_mulDone) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Single-cycle ops are captured at the accept edge and evaluated in the
    // following cycle, which gives latency 1 and lets ADC see a carry that was
    // written on the same edge it was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            r_pend <= w_accept && (op != OP_MUL);
            if (w_accept) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
            end
        end
    end

    // Datapath for the single-cycle ops, computed one bit wider than the
    // operands so the carry/borrow falls out of the top bit. PASSA leaves C
    // and V at their current register values.
    always_comb begin
        w_sum   = '0;
        w_res   = '0;
        w_c     = flags[FLAG_C];
        w_v     = flags[FLAG_V];
        w_legal = 1'b1;
        case (r_op)
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b}
                      + {{WIDTH{1'b0}}, (r_op == OP_ADC) && flags[FLAG_C]};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, r_a} - {1'b0, r_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = ~w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: begin
                w_res = r_a & r_b;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_OR: begin
                w_res = r_a | r_b;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_XOR: begin
                w_res = r_a ^ r_b;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_NOTA: begin
                w_res = ~r_a;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
            OP_PASSA: begin
                w_res = r_a;
            end
            OP_SHL: begin
                w_res = r_a << 1;
                w_c   = r_a[WIDTH-1];
                w_v   = 1'b0;
            end
            OP_SHR: begin
                w_res = r_a >> 1;
                w_c   = r_a[0];
                w_v   = 1'b0;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        w_flagsNext         = '0;
        w_flagsNext[FLAG_V] = w_v;
        w_flagsNext[FLAG_Z] = (w_res == '0);
        w_flagsNext[FLAG_N] = w_res[WIDTH-1];
        w_flagsNext[FLAG_C] = w_c;

        w_mulFlags          = '0;
        w_mulFlags[FLAG_Z]  = (w_prod[WIDTH-1:0] == '0);
        w_mulFlags[FLAG_N]  = w_prod[WIDTH-1];
        w_mulFlags[FLAG_C]  = |w_prod[2*WIDTH-1:WIDTH];
    end

    // Output registers: result and flags always move together. A finished
    // multiply and a pending single-cycle op can never coincide because the
    // ALU accepts nothing while multiplying. Illegal ops only pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            if (r_state == ST_DONE) begin
                result    <= w_prod[WIDTH-1:0];
                flags     <= w_mulFlags;
                out_valid <= 1'b1;
            end else if (r_pend) begin
                out_valid <= 1'b1;
                if (w_legal) begin
                    result <= w_res;
                    flags  <= w_flagsNext;
                end else begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
// Scoreboard bench for alu_seq at WIDTH=4: each accepted op pushes the
// expected result/flags/latency from a reference model; the monitor pops
// and compares on every out_valid.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [3:0] res;
        logic [3:0] flg;
        logic       ill;
        int         acc;
        int         lat;
        string      tag;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         out_valid;
    logic         illegal;

    int   nCompared   = 0;
    int   nMismatched = 0;
    int   cyc         = 0;
    int   ovCount     = 0;
    exp_t sbQ[$];
    exp_t mon;

    logic [3:0] mRes   = '0;
    logic [3:0] mFlags = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .flags     (flags),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency from accept to out_valid.
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model working on plain integers; updates the model's
    // architectural result/flags as each op is accepted.
    function automatic exp_t modelOp(input logic [3:0] opIn, input logic [3:0] aIn, input logic [3:0] bIn);
        exp_t e;
        int ai;
        int bi;
        int full;
        logic [3:0] r;
        logic c;
        logic v;
        logic ill;
        ai = int'(aIn);
        bi = int'(bIn);
        r = mRes;
        c = mFlags[0];
        v = mFlags[3];
        ill = 1'b0;
        case (opIn)
            OP_ADD, OP_ADC: begin
                full = ai + bi + ((opIn == OP_ADC) ? int'(mFlags[0]) : 0);
                r = 4'(full);
                c = (full > 15);
                v = (aIn[3] == bIn[3]) && (r[3] != aIn[3]);
            end
            OP_SUB: begin
                r = 4'(ai - bi + 16);
                c = (ai >= bi);
                v = (aIn[3] != bIn[3]) && (r[3] != aIn[3]);
            end
            OP_AND:   begin r = aIn & bIn; c = 0; v = 0; end
            OP_OR:    begin r = aIn | bIn; c = 0; v = 0; end
            OP_XOR:   begin r = aIn ^ bIn; c = 0; v = 0; end
            OP_NOTA:  begin r = 4'(15 - ai); c = 0; v = 0; end
            OP_PASSA: begin r = aIn; end
            OP_SHL:   begin r = 4'((ai * 2) % 16); c = aIn[3]; v = 0; end
            OP_SHR:   begin r = 4'(ai / 2); c = aIn[0]; v = 0; end
            OP_MUL: begin
                full = ai * bi;
                r = 4'(full % 16);
                c = (full > 15);
                v = 0;
            end
            default: ill = 1'b1;
        endcase
        if (!ill) begin
            mRes   = r;
            mFlags = {v, (r == 4'd0), r[3], c};
        end
        e.res = mRes;
        e.flg = mFlags;
        e.ill = ill;
        e.acc = cyc;
        e.lat = (opIn == OP_MUL) ? W + 1 : 1;
        e.tag = $sformatf("op%0h_%0h_%0h", opIn, aIn, bIn);
        return e;
    endfunction

    // Waits (bounded) for in_ready, drives one request for one edge and,
    // if an output is expected, pushes the model's prediction.
    task automatic applyStimulus(input logic [3:0] opIn, input logic [3:0] aIn, input logic [3:0] bIn, input bit expectOut);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        op = opIn;
        a = aIn;
        b = bIn;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (expectOut) sbQ.push_back(modelOp(opIn, aIn, bIn));
    endtask

    // Bounded wait until every predicted output has been seen.
    task automatic waitDrain();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (sbQ.size() != 0 && n < 100);
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 32'(sbQ.size()), 32'd0);
            sbQ.delete();
        end
    endtask

    // Monitor: compares each out_valid against the oldest prediction.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            ovCount++;
            if (sbQ.size() == 0) begin
                checkOutput("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                mon = sbQ.pop_front();
                checkOutput({mon.tag, "_result"}, 32'(result), 32'(mon.res));
                checkOutput({mon.tag, "_flags"}, 32'(flags), 32'(mon.flg));
                checkOutput({mon.tag, "_illegal"}, 32'(illegal), 32'(mon.ill));
                checkOutput({mon.tag, "_latency"}, 32'(cyc - mon.acc), 32'(mon.lat));
            end
        end
    end

    initial begin
        int ovSnap;
        rst = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(OP_ADD, 4'b0111, 4'b0001, 1);
        waitDrain();
        checkOutput("add_ovf_result", 32'(result), 32'b1000);
        checkOutput("add_ovf_flags", 32'(flags), 32'b1010);

        applyStimulus(OP_ADD, 4'b1111, 4'b0001, 1);
        waitDrain();
        checkOutput("add_carry_flags", 32'(flags), 32'b0101);

        applyStimulus(OP_SUB, 4'b0011, 4'b0101, 1);
        waitDrain();
        checkOutput("sub_borrow_result", 32'(result), 32'b1110);
        checkOutput("sub_borrow_flags", 32'(flags), 32'b0010);

        applyStimulus(OP_SUB, 4'b0101, 4'b0011, 1);
        waitDrain();
        checkOutput("sub_noborrow_flags", 32'(flags), 32'b0001);

        // Back-to-back ADC must see the carry written on its accept edge.
        applyStimulus(OP_ADD, 4'b1111, 4'b0001, 1);
        applyStimulus(OP_ADC, 4'b0000, 4'b0000, 1);
        waitDrain();
        checkOutput("adc_b2b_result", 32'(result), 32'b0001);
        checkOutput("adc_b2b_flags", 32'(flags), 32'b0000);

        // PASSA keeps V and C from the preceding ADD.
        applyStimulus(OP_ADD, 4'b0111, 4'b0001, 1);
        applyStimulus(OP_PASSA, 4'b0000, 4'b0000, 1);
        waitDrain();
        checkOutput("passa_keep_flags", 32'(flags), 32'b1100);

        // MUL with requests poked while busy; they must be ignored.
        applyStimulus(OP_MUL, 4'b0101, 4'b0011, 1);
        op = OP_ADD;
        a = 4'd1;
        b = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mul_busy_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        waitDrain();
        checkOutput("mul_result", 32'(result), 32'b1111);
        checkOutput("mul_flags", 32'(flags), 32'b0010);

        applyStimulus(OP_MUL, 4'b1111, 4'b0010, 1);
        waitDrain();
        checkOutput("mul_hi_result", 32'(result), 32'b1110);
        checkOutput("mul_hi_carry", 32'(flags[0]), 32'd1);

        // Illegal op: pulse only, state untouched.
        applyStimulus(4'b1111, 4'b0011, 4'b0011, 1);
        waitDrain();
        checkOutput("illegal_keep_result", 32'(result), 32'b1110);

        // Reset during the second multiply cycle aborts it.
        applyStimulus(OP_MUL, 4'b0101, 4'b0011, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mRes = '0;
        mFlags = '0;
        #1;
        checkOutput("abort_result", 32'(result), 32'd0);
        checkOutput("abort_flags", 32'(flags), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        ovSnap = ovCount;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_out_valid", 32'(ovCount), 32'(ovSnap));

        // Random mix, including illegal codes and multiplies.
        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1);
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
